// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_FAST_EN: zero-operand multiplies and divide special cases bypass CALC.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      alu_ctrl,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  state_t          w_state_calc;
  state_t          w_state_nxt;
  logic [2:0]      w_op_nxt;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [XLEN-1:0] w_b_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_neg_q_nxt;
  logic            w_neg_r_nxt;
  logic            w_dz_nxt;
  logic            w_ovf_nxt;
  logic [XLEN-1:0] w_res_nxt;

  logic            w_accept;
  logic            w_sa;
  logic            w_sb;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_in_dz;
  logic            w_in_ovf;
  logic            w_fast;

  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_mul_hi;
  logic [XLEN-1:0] w_mul_lo;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_rem_sub;
  logic            w_ge;
  logic [XLEN-1:0] w_div_hi;
  logic [XLEN-1:0] w_div_lo;

  // Sign handling: magnitudes are iterated on, signs are restored in DONE.
  function automatic logic [XLEN-1:0] f_correct(
    input logic [2:0]      op,
    input logic [XLEN-1:0] hi,
    input logic [XLEN-1:0] lo,
    input logic            neg_q,
    input logic            neg_r,
    input logic            dz,
    input logic            ovf
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = neg_q ? ({(2*XLEN){1'b0}} - {hi, lo}) : {hi, lo};
    quo  = neg_q ? ({XLEN{1'b0}} - lo) : lo;
    rem  = neg_r ? ({XLEN{1'b0}} - hi) : hi;
    case (op)
      3'b000:                 f_correct = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: f_correct = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         f_correct = dz ? {XLEN{1'b1}} : (ovf ? W_MIN : quo);
      3'b110, 3'b111:         f_correct = ovf ? {XLEN{1'b0}} : rem;
      default:                f_correct = {XLEN{1'b0}};
    endcase
  endfunction

  // Operand signedness per op: MULHSU treats b as unsigned.
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (alu_ctrl[2:0])
      3'b001, 3'b100, 3'b110: begin
        w_sa = 1'b1;
        w_sb = 1'b1;
      end
      3'b010: begin
        w_sa = 1'b1;
        w_sb = 1'b0;
      end
      default: begin
        w_sa = 1'b0;
        w_sb = 1'b0;
      end
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && start && (alu_ctrl[5:3] == 3'b011);
  assign w_a_neg  = w_sa & operand_a[XLEN-1];
  assign w_b_neg  = w_sb & operand_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? ({XLEN{1'b0}} - operand_a) : operand_a;
  assign w_b_mag  = w_b_neg ? ({XLEN{1'b0}} - operand_b) : operand_b;
  assign w_in_dz  = alu_ctrl[2] & (operand_b == {XLEN{1'b0}});
  assign w_in_ovf = alu_ctrl[2] & ~alu_ctrl[0] & (operand_a == W_MIN) &
                    (operand_b == {XLEN{1'b1}});

`ifdef MULDIV_FAST_EN
  assign w_fast = w_in_dz | w_in_ovf |
                  (~alu_ctrl[2] & ((operand_a == {XLEN{1'b0}}) | (operand_b == {XLEN{1'b0}})));
`else
  assign w_fast = 1'b0;
`endif

  // Multiply step: r_hi accumulates, r_lo holds the multiplier and collects product low bits.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_mul_hi = w_sum[XLEN:1];
  assign w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};

  // Divide step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
  assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_b};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_div_hi  = w_ge ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_div_lo  = {r_lo[XLEN-2:0], w_ge};

  // Next-state and datapath load/iterate decisions.
  always_comb begin
    w_state_calc = r_state;
    w_op_nxt     = r_op;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_b_nxt      = r_b;
    w_cnt_nxt    = r_cnt;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_dz_nxt     = r_dz;
    w_ovf_nxt    = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt    = alu_ctrl[2:0];
          w_neg_q_nxt = w_a_neg ^ w_b_neg;
          w_neg_r_nxt = w_a_neg;
          w_dz_nxt    = w_in_dz;
          w_ovf_nxt   = w_in_ovf;
          w_hi_nxt    = {XLEN{1'b0}};
          w_lo_nxt    = alu_ctrl[2] ? w_a_mag : w_b_mag;
          w_b_nxt     = alu_ctrl[2] ? w_b_mag : w_a_mag;
          if (w_fast) begin
            // Preload the values the full iteration would have produced.
            w_state_calc = S_DONE;
            w_cnt_nxt    = {CW{1'b0}};
            w_hi_nxt     = w_in_dz ? w_a_mag : {XLEN{1'b0}};
            w_lo_nxt     = alu_ctrl[2] ? w_a_mag : {XLEN{1'b0}};
          end else begin
            w_state_calc = S_CALC;
            w_cnt_nxt    = CW'(XLEN);
          end
        end else begin
          w_state_calc = S_IDLE;
        end
      end
      S_CALC: begin
        w_hi_nxt  = r_op[2] ? w_div_hi : w_mul_hi;
        w_lo_nxt  = r_op[2] ? w_div_lo : w_mul_lo;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_calc = S_DONE;
        end else begin
          w_state_calc = S_CALC;
        end
      end
      S_DONE:  w_state_calc = S_IDLE;
      default: w_state_calc = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_calc;
    end
  end

  assign w_res_nxt = f_correct(w_op_nxt, w_hi_nxt, w_lo_nxt, w_neg_q_nxt, w_neg_r_nxt,
                               w_dz_nxt, w_ovf_nxt);

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= 3'b000;
      r_hi     <= {XLEN{1'b0}};
      r_lo     <= {XLEN{1'b0}};
      r_b      <= {XLEN{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_b      <= w_b_nxt;
      r_cnt    <= w_cnt_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_dz     <= w_dz_nxt;
      r_ovf    <= w_ovf_nxt;
      r_busy   <= (w_state_nxt == S_CALC);
      r_done   <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        r_result <= w_res_nxt;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
